watch_timebase: RTL and testbench

Parametrised successor to the fixed 10000-count tick divider that drives the watch display. Combines a configurable prescaler with a BCD HH:MM:SS time counter in 24 h or 12 h format, a synchronous time load with range checking, and an armable alarm with acknowledge and timeout. It sits between the board clock and the display/segment driver, and replaces the ad-hoc tim_en/tim_over logic.

---
 rtl/watch_timebase.sv | 247 ++++++++++++++++++++++++
 tb/tb_watch_timebase.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/watch_timebase.sv
// watch_timebase: seconds timebase and BCD clock with load and alarm.
//
// A prescaler divides clk down to a seconds tick. The tick period is
// CLK_HZ/TICK_HZ cycles, or FAST_DIV cycles when fast=1. Each tick advances
// an HH:MM:SS BCD counter. Hours run 00..23, or 12,01..11 with a pm flag
// when MODE12=1. A load with range checking sets the time. An armed alarm
// fires when a tick reaches HH:MM:00 equal to the alarm time. It stays high
// for ALARM_LEN ticks, or until it is acknowledged or disarmed.
//
// Ports:
//   clk, rstn                  clock (rising edge), async active-low reset
//   run, fast                  prescaler enable, fast terminal select
//   load, *_init, pm_init      synchronous time load
//   alarm_wr, alarm_h*/m*, alarm_pm, alarm_disarm, alarm_ack
//                              alarm programming and control
//   *_now, pm                  current time (BCD) and pm flag
//   sec_tick, min_tick         one-cycle pulses aligned with the new time
//   load_err                   one-cycle pulse: a load was rejected
//   alarm_armed, alarm         alarm state
module watch_timebase #(
  parameter int CLK_HZ    = 100000000,
  parameter int TICK_HZ   = 1,
  parameter int FAST_DIV  = 1000,
  parameter int MODE12    = 0,
  parameter int ALARM_LEN = 60
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       run,
  input  logic       fast,
  input  logic       load,
  input  logic [3:0] hourdec_init,
  input  logic [3:0] hourone_init,
  input  logic [3:0] mindec_init,
  input  logic [3:0] minone_init,
  input  logic [3:0] secdec_init,
  input  logic [3:0] secone_init,
  input  logic       pm_init,
  input  logic       alarm_wr,
  input  logic [3:0] alarm_hdec,
  input  logic [3:0] alarm_hone,
  input  logic [3:0] alarm_mdec,
  input  logic [3:0] alarm_mone,
  input  logic       alarm_pm,
  input  logic       alarm_disarm,
  input  logic       alarm_ack,
  output logic [3:0] hourdec_now,
  output logic [3:0] hourone_now,
  output logic [3:0] mindec_now,
  output logic [3:0] minone_now,
  output logic [3:0] secdec_now,
  output logic [3:0] secone_now,
  output logic       pm,
  output logic       sec_tick,
  output logic       min_tick,
  output logic       load_err,
  output logic       alarm_armed,
  output logic       alarm
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int AW  = $clog2(ALARM_LEN + 1);
  localparam logic [PW-1:0] TERM_NORM_C = PW'(DIV - 1);
  localparam logic [PW-1:0] TERM_FAST_C = PW'(FAST_DIV - 1);
  localparam logic [3:0] HDEC_RST_C = (MODE12 != 0) ? 4'd1 : 4'd0;
  localparam logic [3:0] HONE_RST_C = (MODE12 != 0) ? 4'd2 : 4'd0;

  // Range check for a time load in the configured hour format.
  function automatic logic load_valid(input logic [3:0] hd, input logic [3:0] ho,
                                      input logic [3:0] md, input logic [3:0] mo,
                                      input logic [3:0] sd, input logic [3:0] so);
    logic hour_ok;
    if (MODE12 != 0) begin
      hour_ok = ((hd == 4'd0) && (ho >= 4'd1) && (ho <= 4'd9)) ||
                ((hd == 4'd1) && (ho <= 4'd2));
    end else begin
      hour_ok = (ho <= 4'd9) && ((hd < 4'd2) || ((hd == 4'd2) && (ho <= 4'd3)));
    end
    return hour_ok && (md <= 4'd5) && (mo <= 4'd9) && (sd <= 4'd5) && (so <= 4'd9);
  endfunction

  // Hour increment, returned as {hourdec, hourone, pm}.
  function automatic logic [8:0] next_hour(input logic [3:0] hd, input logic [3:0] ho,
                                           input logic p);
    logic [8:0] r;
    if (MODE12 != 0) begin
      if ((hd == 4'd1) && (ho == 4'd1)) begin
        r = {4'd1, 4'd2, ~p};            // 11 -> 12 crosses noon/midnight
      end else if ((hd == 4'd1) && (ho == 4'd2)) begin
        r = {4'd0, 4'd1, p};             // 12 -> 01 keeps the half of day
      end else if (ho == 4'd9) begin
        r = {hd + 4'd1, 4'd0, p};
      end else begin
        r = {hd, ho + 4'd1, p};
      end
    end else begin
      if ((hd == 4'd2) && (ho == 4'd3)) begin
        r = {4'd0, 4'd0, 1'b0};
      end else if (ho == 4'd9) begin
        r = {hd + 4'd1, 4'd0, 1'b0};
      end else begin
        r = {hd, ho + 4'd1, 1'b0};
      end
    end
    return r;
  endfunction

  logic [PW-1:0] cnt_r;
  logic [3:0]    hd_r, ho_r, md_r, mo_r, sd_r, so_r;
  logic          pm_r, sec_tick_r, min_tick_r, load_err_r;
  logic [3:0]    al_hd_r, al_ho_r, al_md_r, al_mo_r;
  logic          al_pm_r, armed_r, alarm_r;
  logic [AW-1:0] al_cnt_r;

  logic [PW-1:0] term_s;
  logic          tick_s, tick_apply_s, load_ok_s, sec_wrap_s, match_s;
  logic [3:0]    nx_so_s, nx_sd_s, nx_mo_s, nx_md_s;
  logic [8:0]    nx_hour_s;

  assign term_s       = fast ? TERM_FAST_C : TERM_NORM_C;
  // >= rather than == so that switching to the shorter terminal mid-count
  // still produces a tick instead of wrapping through the whole counter.
  assign tick_s       = run && (cnt_r >= term_s);
  assign load_ok_s    = load && load_valid(hourdec_init, hourone_init, mindec_init,
                                           minone_init, secdec_init, secone_init);
  assign tick_apply_s = tick_s && !load;
  assign match_s      = armed_r && tick_apply_s && sec_wrap_s &&
                        (nx_hour_s[8:5] == al_hd_r) && (nx_hour_s[4:1] == al_ho_r) &&
                        (nx_md_s == al_md_r) && (nx_mo_s == al_mo_r) &&
                        (nx_hour_s[0] == al_pm_r);

  // BCD ripple of the time value one second ahead.
  always_comb begin
    nx_so_s    = so_r + 4'd1;
    nx_sd_s    = sd_r;
    nx_mo_s    = mo_r;
    nx_md_s    = md_r;
    nx_hour_s  = {hd_r, ho_r, pm_r};
    sec_wrap_s = 1'b0;
    if (so_r == 4'd9) begin
      nx_so_s = 4'd0;
      if (sd_r == 4'd5) begin
        nx_sd_s    = 4'd0;
        sec_wrap_s = 1'b1;
        if (mo_r == 4'd9) begin
          nx_mo_s = 4'd0;
          if (md_r == 4'd5) begin
            nx_md_s   = 4'd0;
            nx_hour_s = next_hour(hd_r, ho_r, pm_r);
          end else begin
            nx_md_s = md_r + 4'd1;
          end
        end else begin
          nx_mo_s = mo_r + 4'd1;
        end
      end else begin
        nx_sd_s = sd_r + 4'd1;
      end
    end else begin
      nx_so_s = so_r + 4'd1;
    end
  end

  // Prescaler: a rejected load leaves it untouched, an accepted one restarts it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_ok_s ? '0 : cnt_r;
    end else if (tick_s) begin
      cnt_r <= '0;
    end else if (run) begin
      cnt_r <= cnt_r + PW'(1);
    end
  end

  // Time registers and the pulses that accompany a new value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hd_r <= HDEC_RST_C; ho_r <= HONE_RST_C;
      md_r <= 4'd0; mo_r <= 4'd0; sd_r <= 4'd0; so_r <= 4'd0;
      pm_r <= 1'b0;
      sec_tick_r <= 1'b0; min_tick_r <= 1'b0; load_err_r <= 1'b0;
    end else begin
      sec_tick_r <= tick_apply_s;
      min_tick_r <= tick_apply_s && sec_wrap_s;
      load_err_r <= load && !load_ok_s;
      if (load_ok_s) begin
        hd_r <= hourdec_init; ho_r <= hourone_init;
        md_r <= mindec_init;  mo_r <= minone_init;
        sd_r <= secdec_init;  so_r <= secone_init;
        pm_r <= (MODE12 != 0) ? pm_init : 1'b0;
      end else if (tick_apply_s) begin
        hd_r <= nx_hour_s[8:5]; ho_r <= nx_hour_s[4:1];
        md_r <= nx_md_s; mo_r <= nx_mo_s;
        sd_r <= nx_sd_s; so_r <= nx_so_s;
        pm_r <= nx_hour_s[0];
      end
    end
  end

  // Alarm registers, arming, and the active-alarm countdown.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      al_hd_r <= HDEC_RST_C; al_ho_r <= HONE_RST_C;
      al_md_r <= 4'd0; al_mo_r <= 4'd0; al_pm_r <= 1'b0;
      armed_r <= 1'b0; alarm_r <= 1'b0; al_cnt_r <= '0;
    end else begin
      if (alarm_wr) begin
        al_hd_r <= alarm_hdec; al_ho_r <= alarm_hone;
        al_md_r <= alarm_mdec; al_mo_r <= alarm_mone;
        al_pm_r <= (MODE12 != 0) ? alarm_pm : 1'b0;
        armed_r <= 1'b1;
      end else if (alarm_disarm) begin
        armed_r <= 1'b0;
      end
      if (alarm_disarm && !alarm_wr) begin
        alarm_r <= 1'b0;
      end else if (match_s) begin
        alarm_r  <= 1'b1;
        al_cnt_r <= AW'(ALARM_LEN);
      end else if (alarm_r) begin
        if (alarm_ack) begin
          alarm_r <= 1'b0;
        end else if (tick_apply_s) begin
          al_cnt_r <= al_cnt_r - AW'(1);
          alarm_r  <= (al_cnt_r != AW'(1));
        end
      end
    end
  end

  assign hourdec_now = hd_r;
  assign hourone_now = ho_r;
  assign mindec_now  = md_r;
  assign minone_now  = mo_r;
  assign secdec_now  = sd_r;
  assign secone_now  = so_r;
  assign pm          = pm_r;
  assign sec_tick    = sec_tick_r;
  assign min_tick    = min_tick_r;
  assign load_err    = load_err_r;
  assign alarm_armed = armed_r;
  assign alarm       = alarm_r;

endmodule

// File: tb/tb_watch_timebase.sv
// Testbench for watch_timebase. It runs a 24 h and a 12 h instance on the
// same stimulus. Each instance is compared every cycle against a model that
// keeps time as seconds-of-day. Directed steps are followed by a random phase.
module tb_watch_timebase;
  localparam int CLK_HZ = 100, TICK_HZ = 1, FAST_DIV = 4, ALARM_LEN = 3;
  localparam int DIV = CLK_HZ / TICK_HZ;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn, run, fast, load, pm_i, alarm_wr, alarm_pm, alarm_disarm, alarm_ack;
  logic [3:0] hd_i, ho_i, md_i, mo_i, sd_i, so_i, a_hd, a_ho, a_md, a_mo;
  logic [3:0] hd_o[2], ho_o[2], md_o[2], mo_o[2], sd_o[2], so_o[2];
  logic pm_o[2], st_o[2], mt_o[2], le_o[2], ar_o[2], al_o[2];

  watch_timebase #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .FAST_DIV(FAST_DIV),
                   .MODE12(0), .ALARM_LEN(ALARM_LEN)) u_dut24 (
    .clk(clk), .rstn(rstn), .run(run), .fast(fast), .load(load),
    .hourdec_init(hd_i), .hourone_init(ho_i), .mindec_init(md_i), .minone_init(mo_i),
    .secdec_init(sd_i), .secone_init(so_i), .pm_init(pm_i),
    .alarm_wr(alarm_wr), .alarm_hdec(a_hd), .alarm_hone(a_ho), .alarm_mdec(a_md),
    .alarm_mone(a_mo), .alarm_pm(alarm_pm), .alarm_disarm(alarm_disarm), .alarm_ack(alarm_ack),
    .hourdec_now(hd_o[0]), .hourone_now(ho_o[0]), .mindec_now(md_o[0]), .minone_now(mo_o[0]),
    .secdec_now(sd_o[0]), .secone_now(so_o[0]), .pm(pm_o[0]), .sec_tick(st_o[0]),
    .min_tick(mt_o[0]), .load_err(le_o[0]), .alarm_armed(ar_o[0]), .alarm(al_o[0]));

  watch_timebase #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .FAST_DIV(FAST_DIV),
                   .MODE12(1), .ALARM_LEN(ALARM_LEN)) u_dut12 (
    .clk(clk), .rstn(rstn), .run(run), .fast(fast), .load(load),
    .hourdec_init(hd_i), .hourone_init(ho_i), .mindec_init(md_i), .minone_init(mo_i),
    .secdec_init(sd_i), .secone_init(so_i), .pm_init(pm_i),
    .alarm_wr(alarm_wr), .alarm_hdec(a_hd), .alarm_hone(a_ho), .alarm_mdec(a_md),
    .alarm_mone(a_mo), .alarm_pm(alarm_pm), .alarm_disarm(alarm_disarm), .alarm_ack(alarm_ack),
    .hourdec_now(hd_o[1]), .hourone_now(ho_o[1]), .mindec_now(md_o[1]), .minone_now(mo_o[1]),
    .secdec_now(sd_o[1]), .secone_now(so_o[1]), .pm(pm_o[1]), .sec_tick(st_o[1]),
    .min_tick(mt_o[1]), .load_err(le_o[1]), .alarm_armed(ar_o[1]), .alarm(al_o[1]));

  // Reference model state, index 0 = 24 h, 1 = 12 h.
  int m_sod[2], m_pre[2], m_acnt[2], m_almin[2];
  bit m_armed[2], m_al[2], m_st[2], m_mt[2], m_le[2];
  int passed = 0, failed = 0, total = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Hour in 0..23 from display digits, or -1 when out of range for the mode.
  function automatic int hour24(int m, int hd, int ho, bit p);
    int hv;
    if (ho > 9) return -1;
    hv = hd * 10 + ho;
    if (m == 0) return (hv <= 23) ? hv : -1;
    return (hv >= 1 && hv <= 12) ? ((hv % 12) + (p ? 12 : 0)) : -1;
  endfunction

  function automatic logic [29:0] exp_vec(int m);
    int h24, h, mn, s;
    bit p;
    h24 = m_sod[m] / 3600; mn = (m_sod[m] / 60) % 60; s = m_sod[m] % 60;
    if (m == 1) begin
      h = (h24 % 12 == 0) ? 12 : h24 % 12;
      p = (h24 >= 12);
    end else begin
      h = h24;
      p = 1'b0;
    end
    return {4'(h / 10), 4'(h % 10), 4'(mn / 10), 4'(mn % 10), 4'(s / 10), 4'(s % 10),
            p, m_st[m], m_mt[m], m_le[m], m_armed[m], m_al[m]};
  endfunction

  function automatic logic [29:0] obs_vec(int m);
    return {hd_o[m], ho_o[m], md_o[m], mo_o[m], sd_o[m], so_o[m],
            pm_o[m], st_o[m], mt_o[m], le_o[m], ar_o[m], al_o[m]};
  endfunction

  function automatic logic [24:0] tim(int m);
    return {hd_o[m], ho_o[m], md_o[m], mo_o[m], sd_o[m], so_o[m], pm_o[m]};
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_sod[m] = 0; m_pre[m] = 0; m_acnt[m] = 0; m_almin[m] = 0;
      m_armed[m] = 0; m_al[m] = 0; m_st[m] = 0; m_mt[m] = 0; m_le[m] = 0;
    end
  endtask

  // Advance the model by one clock using the inputs now applied.
  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      int t, h;
      bit tick, tapp, match;
      t = fast ? FAST_DIV - 1 : DIV - 1;
      tick = run && (m_pre[m] >= t);
      tapp = 0; m_st[m] = 0; m_mt[m] = 0; m_le[m] = 0;
      if (load) begin
        h = hour24(m, hd_i, ho_i, pm_i);
        if (h >= 0 && md_i <= 5 && mo_i <= 9 && sd_i <= 5 && so_i <= 9) begin
          m_sod[m] = h * 3600 + (md_i * 10 + mo_i) * 60 + sd_i * 10 + so_i;
          m_pre[m] = 0;
        end else m_le[m] = 1;
      end else if (tick) begin
        m_pre[m] = 0;
        m_sod[m] = (m_sod[m] + 1) % 86400;
        tapp = 1; m_st[m] = 1; m_mt[m] = (m_sod[m] % 60 == 0);
      end else if (run) m_pre[m]++;
      match = m_armed[m] && tapp && (m_sod[m] % 60 == 0) && (m_sod[m] / 60 == m_almin[m]);
      if (alarm_disarm && !alarm_wr) m_al[m] = 0;
      else if (match) begin m_al[m] = 1; m_acnt[m] = ALARM_LEN; end
      else if (m_al[m]) begin
        if (alarm_ack) m_al[m] = 0;
        else if (tapp) begin
          m_acnt[m]--;
          if (m_acnt[m] == 0) m_al[m] = 0;
        end
      end
      if (alarm_wr) begin
        h = hour24(m, a_hd, a_ho, alarm_pm);
        m_almin[m] = (h >= 0 && a_md <= 5 && a_mo <= 9) ? h * 60 + a_md * 10 + a_mo : -1;
        m_armed[m] = 1;
      end else if (alarm_disarm) m_armed[m] = 0;
    end
  endtask

  // One clock: model, edge, compare both instances, drop pulse inputs.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("cyc24", 32'(obs_vec(0)), 32'(exp_vec(0)));
    check("cyc12", 32'(obs_vec(1)), 32'(exp_vec(1)));
    load = 0; alarm_wr = 0; alarm_disarm = 0; alarm_ack = 0;
  endtask

  task automatic set_load(int hd, int ho, int md, int mo, int sd, int so, bit p);
    hd_i = 4'(hd); ho_i = 4'(ho); md_i = 4'(md); mo_i = 4'(mo); sd_i = 4'(sd); so_i = 4'(so);
    pm_i = p; load = 1;
  endtask

  task automatic set_alarm(int hd, int ho, int md, int mo, bit p);
    a_hd = 4'(hd); a_ho = 4'(ho); a_md = 4'(md); a_mo = 4'(mo); alarm_pm = p; alarm_wr = 1;
  endtask

  task automatic wait_tick(int m, int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit && n < 0; i++) begin
      cycle();
      if (st_o[m]) n = i;
    end
  endtask

  task automatic wait_alarm(int limit);
    bit seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      cycle();
      seen = al_o[0];
    end
  endtask

  initial begin
    int n, c1, c2, ticks;
    logic [24:0] saved;
    rstn = 1; run = 0; fast = 0; load = 0; pm_i = 0; alarm_wr = 0; alarm_pm = 0;
    alarm_disarm = 0; alarm_ack = 0;
    hd_i = 4'd0; ho_i = 4'd0; md_i = 4'd0; mo_i = 4'd0; sd_i = 4'd0; so_i = 4'd0;
    a_hd = 4'd0; a_ho = 4'd0; a_md = 4'd0; a_mo = 4'd0;
    #1 rstn = 0;
    model_reset();
    #1;
    check("reset24", 32'(obs_vec(0)), 32'(exp_vec(0)));
    check("reset12_time", 32'(tim(1)), 32'({24'h120000, 1'b0}));
    @(posedge clk); #1;
    rstn = 1; run = 1; fast = 0;

    // First tick DIV cycles after release, then frozen while run=0.
    wait_tick(0, 200, n);
    check("first_tick_cycles", 32'(n), 32'd100);
    check("first_tick_secone", 32'(so_o[0]), 32'd1);
    run = 0; ticks = 0;
    repeat (150) begin cycle(); ticks += int'(st_o[0]); end
    check("frozen_no_tick", 32'(ticks), 32'd0);

    // Midnight rollover in fast mode.
    run = 1; fast = 1;
    set_load(2, 3, 5, 9, 5, 8, 0);
    cycle();
    ticks = 0; c1 = 0; c2 = 0;
    for (int i = 1; i <= 20 && ticks < 2; i++) begin
      cycle();
      if (st_o[0]) begin
        ticks++;
        if (ticks == 1) c1 = i; else c2 = i;
      end
    end
    check("fast_first_tick", 32'(c1), 32'd4);
    check("fast_spacing", 32'(c2 - c1), 32'd4);
    check("midnight_time", 32'(tim(0)), 32'({24'h000000, 1'b0}));
    check("midnight_min_tick", 32'(mt_o[0]), 32'd1);
    check("err12_on_23h", 32'(m_sod[1] != 86398), 32'd1);

    // 12 h transitions.
    set_load(1, 1, 5, 9, 5, 9, 0);
    cycle();
    wait_tick(1, 10, n);
    check("12h_noon", 32'(tim(1)), 32'({24'h120000, 1'b1}));
    set_load(1, 2, 5, 9, 5, 9, 1);
    cycle();
    wait_tick(1, 10, n);
    check("12h_one_pm", 32'(tim(1)), 32'({24'h010000, 1'b1}));

    // Rejected loads, then load colliding with a tick.
    run = 0;
    saved = tim(0);
    set_load(2, 4, 0, 0, 0, 0, 0);
    cycle();
    check("bad_hour_err24", 32'(le_o[0]), 32'd1);
    check("bad_hour_err12", 32'(le_o[1]), 32'd1);
    check("bad_hour_keep", 32'(tim(0)), 32'(saved));
    cycle();
    check("err_one_cycle", 32'(le_o[0]), 32'd0);
    set_load(1, 0, 0, 10, 0, 0, 0);
    cycle();
    check("bad_min_err24", 32'(le_o[0]), 32'd1);
    check("bad_min_keep", 32'(tim(0)), 32'(saved));
    run = 1; fast = 1;
    for (int i = 0; i < 10 && m_pre[0] != FAST_DIV - 1; i++) cycle();
    set_load(1, 0, 2, 0, 3, 0, 0);
    cycle();
    check("load_over_tick_val", 32'(tim(0)), 32'({24'h102030, 1'b0}));
    check("load_over_tick_nost", 32'(st_o[0]), 32'd0);

    // Alarm: full length, then acknowledged.
    set_alarm(0, 7, 3, 0, 0);
    set_load(0, 7, 2, 9, 5, 9, 0);
    cycle();
    wait_alarm(20);
    check("alarm_rise_time", 32'(tim(0)), 32'({24'h073000, 1'b0}));
    check("alarm_rise12", 32'(al_o[1]), 32'd1);
    n = 0;
    for (int i = 0; i < 40 && al_o[0]; i++) begin
      cycle();
      n += int'(st_o[0]);
    end
    check("alarm_len_ticks", 32'(n), 32'd3);
    set_load(0, 7, 2, 9, 5, 9, 0);
    cycle();
    wait_alarm(20);
    wait_tick(0, 10, n);
    check("alarm_held", 32'(al_o[0]), 32'd1);
    alarm_ack = 1;
    cycle();
    check("ack_clears", 32'(al_o[0]), 32'd0);
    check("ack_keeps_armed", 32'(ar_o[0]), 32'd1);

    // Switch to fast with the prescaler at 50.
    fast = 0;
    set_load(0, 1, 0, 0, 0, 0, 0);
    cycle();
    repeat (50) cycle();
    fast = 1;
    cycle();
    check("fast_switch_tick", 32'(st_o[0]), 32'd1);
    n = 0;
    repeat (3) begin cycle(); n += int'(st_o[0]); end
    check("post_switch_quiet", 32'(n), 32'd0);
    cycle();
    check("post_switch_tick", 32'(st_o[0]), 32'd1);

    // Reset while the alarm is active.
    set_alarm(0, 1, 0, 1, 0);
    set_load(0, 1, 0, 0, 5, 9, 0);
    cycle();
    wait_alarm(20);
    check("pre_reset_alarm", 32'(al_o[0]), 32'd1);
    rstn = 0;
    model_reset();
    #1;
    check("rst_alarm24", 32'({al_o[0], ar_o[0]}), 32'd0);
    check("rst_alarm12", 32'({al_o[1], ar_o[1]}), 32'd0);
    check("rst_all12", 32'(obs_vec(1)), 32'(exp_vec(1)));
    @(posedge clk); #1;
    rstn = 1;
    wait_tick(0, 20, n);
    check("post_reset_tick", 32'(n), 32'(FAST_DIV));

    // Random phase against the model.
    for (int i = 0; i < 3000; i++) begin
      run = ($urandom_range(0, 9) != 0);
      fast = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 79) == 0) begin
        if ($urandom_range(0, 3) == 0)
          set_load($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 6),
                   $urandom_range(0, 10), $urandom_range(0, 6), $urandom_range(0, 10),
                   1'($urandom_range(0, 1)));
        else
          set_load(0, $urandom_range(1, 9), $urandom_range(0, 5), $urandom_range(0, 9), 5,
                   $urandom_range(0, 9), 1'b0);
      end
      if ($urandom_range(0, 149) == 0) begin
        n = (m_sod[0] / 60 + 1) % 1440;
        set_alarm((n / 60) / 10, (n / 60) % 10, (n % 60) / 10, (n % 60) % 10, 1'b0);
      end
      if ($urandom_range(0, 299) == 0) alarm_disarm = 1;
      if ($urandom_range(0, 49) == 0) alarm_ack = 1;
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
